// File: rtl/usb_ep_in_pingpong.sv
// IN-endpoint buffer manager: two ping-pong packet banks per endpoint, DATA0/DATA1
// toggle tracking, NAK generation when nothing is armed, and retry on handshake timeout.
module usb_ep_in_pingpong #(
    parameter int NUM_EP = 2,
    parameter int EPW    = 1,
    parameter int AW     = 6,
    parameter int MAXPKT = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [EPW-1:0]    wr_ep_i,
    input  logic              wr_en_i,
    input  logic [7:0]        wr_data_i,
    input  logic              wr_last_i,
    output logic              wr_ready_o,
    output logic [NUM_EP-1:0] wr_ovf_o,
    input  logic              tx_req_i,
    input  logic [EPW-1:0]    tx_ep_i,
    output logic              tx_valid_o,
    output logic              tx_nak_o,
    output logic [AW:0]       tx_len_o,
    output logic              tx_data1_o,
    input  logic              tx_rd_i,
    output logic [7:0]        tx_data_o,
    input  logic              tx_ack_i,
    input  logic              tx_timeout_i,
    input  logic              cfg_clr_i
);
    localparam int          RAW      = EPW + 1 + AW;
    localparam int          DEPTH    = NUM_EP * 2 * (2 ** AW);
    localparam logic [AW:0] MAXPKT_L = (AW+1)'(MAXPKT);
    localparam logic [EPW:0] NUM_EP_L = (EPW+1)'(NUM_EP);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_e;

    logic [7:0]        mem_q [DEPTH];

    logic              wbank_q  [NUM_EP];
    logic [AW-1:0]     wptr_q   [NUM_EP];
    logic              rbank_q  [NUM_EP];
    logic              toggle_q [NUM_EP];
    logic              full_q   [NUM_EP][2];
    logic [AW:0]       len_q    [NUM_EP][2];
    logic [NUM_EP-1:0] ovf_q;

    state_e            state_q, state_d;
    logic [EPW-1:0]    ep_q, ep_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic              tx_valid_q, tx_valid_d;
    logic              tx_nak_q, tx_nak_d;
    logic [AW:0]       tx_len_q, tx_len_d;
    logic              tx_data1_q, tx_data1_d;
    logic [7:0]        tx_data_q;

    logic              wr_ep_ok_s, wr_bank_s, wr_full_s, wr_free_s;
    logic              wr_store_s, wr_commit_s, wr_drop_s;
    logic [AW-1:0]     wr_ptr_s;
    logic [AW:0]       wr_ptr_p1_s, wr_len_s;
    logic [RAW-1:0]    wr_addr_s, rd_addr_s;
    logic              rq_ep_ok_s, rq_bank_s, rq_full_s, cur_bank_s;
    logic              ack_fire_s, rd_fire_s;

    // Producer-side decode for the endpoint selected by wr_ep_i.
    always_comb begin
        wr_ep_ok_s  = ({1'b0, wr_ep_i} < NUM_EP_L);
        wr_bank_s   = wbank_q[wr_ep_i];
        wr_full_s   = full_q[wr_ep_i][wr_bank_s];
        wr_ptr_s    = wptr_q[wr_ep_i];
        wr_ptr_p1_s = {1'b0, wr_ptr_s} + {{AW{1'b0}}, 1'b1};
        wr_free_s   = wr_ep_ok_s && !wr_full_s;
        wr_store_s  = !cfg_clr_i && wr_free_s && wr_en_i;
        wr_commit_s = !cfg_clr_i && wr_free_s &&
                      (wr_last_i || (wr_en_i && (wr_ptr_p1_s == MAXPKT_L)));
        // A bare wr_last commits what is already there, so an empty bank becomes a ZLP.
        wr_len_s    = wr_en_i ? wr_ptr_p1_s : {1'b0, wr_ptr_s};
        wr_drop_s   = !cfg_clr_i && wr_ep_ok_s && wr_full_s && wr_en_i;
        wr_addr_s   = {wr_ep_i, wr_bank_s, wr_ptr_s};
    end

    assign wr_ready_o = wr_free_s;
    assign wr_ovf_o   = ovf_q;

    // SIE-side decode: bank addressed by the token and bank currently armed.
    always_comb begin
        rq_ep_ok_s = ({1'b0, tx_ep_i} < NUM_EP_L);
        rq_bank_s  = rbank_q[tx_ep_i];
        rq_full_s  = rq_ep_ok_s && full_q[tx_ep_i][rq_bank_s];
        cur_bank_s = rbank_q[ep_q];
        rd_addr_s  = {ep_q, cur_bank_s, rptr_q[AW-1:0]};
    end

    // Transmit FSM next-state and registered-output next values.
    always_comb begin
        state_d    = state_q;
        ep_d       = ep_q;
        rptr_d     = rptr_q;
        tx_valid_d = tx_valid_q;
        tx_nak_d   = 1'b0;
        tx_len_d   = tx_len_q;
        tx_data1_d = tx_data1_q;
        ack_fire_s = 1'b0;
        rd_fire_s  = 1'b0;
        if (cfg_clr_i) begin
            state_d    = ST_IDLE;
            rptr_d     = {(AW+1){1'b0}};
            tx_valid_d = 1'b0;
            tx_len_d   = {(AW+1){1'b0}};
            tx_data1_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tx_req_i && rq_full_s) begin
                        state_d    = ST_ARMED;
                        ep_d       = tx_ep_i;
                        rptr_d     = {(AW+1){1'b0}};
                        tx_valid_d = 1'b1;
                        tx_len_d   = len_q[tx_ep_i][rq_bank_s];
                        tx_data1_d = toggle_q[tx_ep_i];
                    end else if (tx_req_i) begin
                        tx_nak_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    // ACK outranks a simultaneous timeout.
                    if (tx_ack_i) begin
                        ack_fire_s = 1'b1;
                        state_d    = ST_IDLE;
                        rptr_d     = {(AW+1){1'b0}};
                        tx_valid_d = 1'b0;
                    end else if (tx_timeout_i) begin
                        state_d    = ST_IDLE;
                        rptr_d     = {(AW+1){1'b0}};
                        tx_valid_d = 1'b0;
                    end else if (tx_rd_i && (rptr_q < tx_len_q)) begin
                        rd_fire_s = 1'b1;
                        rptr_d    = rptr_q + {{AW{1'b0}}, 1'b1};
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Transmit FSM state and registered SIE outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            ep_q       <= {EPW{1'b0}};
            rptr_q     <= {(AW+1){1'b0}};
            tx_valid_q <= 1'b0;
            tx_nak_q   <= 1'b0;
            tx_len_q   <= {(AW+1){1'b0}};
            tx_data1_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ep_q       <= ep_d;
            rptr_q     <= rptr_d;
            tx_valid_q <= tx_valid_d;
            tx_nak_q   <= tx_nak_d;
            tx_len_q   <= tx_len_d;
            tx_data1_q <= tx_data1_d;
        end
    end

    // Registered RAM read port feeding tx_data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_data_q <= 8'h00;
        end else if (rd_fire_s) begin
            tx_data_q <= mem_q[rd_addr_s];
        end
    end

    // Packet RAM write port.
    always_ff @(posedge clk_i) begin
        if (wr_store_s) begin
            mem_q[wr_addr_s] <= wr_data_i;
        end
    end

    // Per-endpoint and per-bank bookkeeping; commit and ack touch different banks.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_EP; i++) begin
                wbank_q[i]  <= 1'b0;
                wptr_q[i]   <= {AW{1'b0}};
                rbank_q[i]  <= 1'b0;
                toggle_q[i] <= 1'b0;
                for (int b = 0; b < 2; b++) begin
                    full_q[i][b] <= 1'b0;
                    len_q[i][b]  <= {(AW+1){1'b0}};
                end
            end
            ovf_q <= {NUM_EP{1'b0}};
        end else if (cfg_clr_i) begin
            for (int i = 0; i < NUM_EP; i++) begin
                wbank_q[i]  <= 1'b0;
                wptr_q[i]   <= {AW{1'b0}};
                rbank_q[i]  <= 1'b0;
                toggle_q[i] <= 1'b0;
                for (int b = 0; b < 2; b++) begin
                    full_q[i][b] <= 1'b0;
                    len_q[i][b]  <= {(AW+1){1'b0}};
                end
            end
            ovf_q <= {NUM_EP{1'b0}};
        end else begin
            if (wr_store_s) begin
                wptr_q[wr_ep_i] <= wr_ptr_p1_s[AW-1:0];
            end
            if (wr_commit_s) begin
                full_q[wr_ep_i][wr_bank_s] <= 1'b1;
                len_q[wr_ep_i][wr_bank_s]  <= wr_len_s;
                wbank_q[wr_ep_i]           <= ~wr_bank_s;
                wptr_q[wr_ep_i]            <= {AW{1'b0}};
            end
            if (wr_drop_s) begin
                ovf_q[wr_ep_i] <= 1'b1;
            end
            if (ack_fire_s) begin
                full_q[ep_q][cur_bank_s] <= 1'b0;
                rbank_q[ep_q]            <= ~cur_bank_s;
                toggle_q[ep_q]           <= ~toggle_q[ep_q];
            end
        end
    end

    assign tx_valid_o = tx_valid_q;
    assign tx_nak_o   = tx_nak_q;
    assign tx_len_o   = tx_len_q;
    assign tx_data1_o = tx_data1_q;
    assign tx_data_o  = tx_data_q;

endmodule

// File: tb/tb_usb_ep_in_pingpong.sv
// Bench for usb_ep_in_pingpong: a packet-FIFO reference model predicts SIE responses
// into a queue; a monitor pops and compares whenever the DUT presents NAK, arm or data.
module tb_usb_ep_in_pingpong;
    localparam int NUM_EP = 2;
    localparam int EPW    = 1;
    localparam int AW     = 6;
    localparam int MAXPKT = 8;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [EPW-1:0]    wr_ep_i;
    logic              wr_en_i;
    logic [7:0]        wr_data_i;
    logic              wr_last_i;
    logic              wr_ready_o;
    logic [NUM_EP-1:0] wr_ovf_o;
    logic              tx_req_i;
    logic [EPW-1:0]    tx_ep_i;
    logic              tx_valid_o;
    logic              tx_nak_o;
    logic [AW:0]       tx_len_o;
    logic              tx_data1_o;
    logic              tx_rd_i;
    logic [7:0]        tx_data_o;
    logic              tx_ack_i;
    logic              tx_timeout_i;
    logic              cfg_clr_i;

    always #5 clk_i = ~clk_i;

    usb_ep_in_pingpong #(.NUM_EP(NUM_EP), .EPW(EPW), .AW(AW), .MAXPKT(MAXPKT)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wr_ep_i(wr_ep_i), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i), .wr_last_i(wr_last_i),
        .wr_ready_o(wr_ready_o), .wr_ovf_o(wr_ovf_o),
        .tx_req_i(tx_req_i), .tx_ep_i(tx_ep_i), .tx_valid_o(tx_valid_o), .tx_nak_o(tx_nak_o),
        .tx_len_o(tx_len_o), .tx_data1_o(tx_data1_o), .tx_rd_i(tx_rd_i), .tx_data_o(tx_data_o),
        .tx_ack_i(tx_ack_i), .tx_timeout_i(tx_timeout_i), .cfg_clr_i(cfg_clr_i)
    );

    // kind: 0 = NAK pulse, 1 = packet armed (val = len, aux = PID), 2 = data byte
    typedef struct {
        int kind;
        int val;
        int aux;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: per endpoint a FIFO of up to two committed packets plus the fill in progress.
    int              m_cnt    [NUM_EP];
    int              m_head   [NUM_EP];
    int              m_plen   [NUM_EP][2];
    bit [7:0]        m_pdata  [NUM_EP][2][64];
    bit [7:0]        m_fill   [NUM_EP][64];
    int              m_fill_n [NUM_EP];
    bit              m_tog    [NUM_EP];
    bit [NUM_EP-1:0] m_ovf;
    bit              m_armed;
    int              m_ep;
    int              m_rptr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push(input int k, input int v, input int a);
        exp_t it;
        it.kind = k;
        it.val  = v;
        it.aux  = a;
        exp_q.push_back(it);
    endfunction

    task automatic model_clear();
        for (int e = 0; e < NUM_EP; e++) begin
            m_cnt[e]    = 0;
            m_head[e]   = 0;
            m_fill_n[e] = 0;
            m_tog[e]    = 1'b0;
        end
        m_ovf   = '0;
        m_armed = 1'b0;
        m_ep    = 0;
        m_rptr  = 0;
    endtask

    task automatic clear_inputs();
        wr_en_i = 1'b0; wr_ep_i = '0; wr_data_i = 8'h00; wr_last_i = 1'b0;
        tx_req_i = 1'b0; tx_ep_i = '0; tx_rd_i = 1'b0; tx_ack_i = 1'b0;
        tx_timeout_i = 1'b0; cfg_clr_i = 1'b0;
    endtask

    // One clock cycle of stimulus; the model is advanced using the state before the edge.
    task automatic cyc(input bit we, input int wep, input int wd, input bit wl,
                       input bit req, input int tep, input bit rd, input bit ack,
                       input bit tmo, input bit clr);
        bit arm_now;
        int s;
        wr_en_i = we; wr_ep_i = wep[EPW-1:0]; wr_data_i = wd[7:0]; wr_last_i = wl;
        tx_req_i = req; tx_ep_i = tep[EPW-1:0]; tx_rd_i = rd; tx_ack_i = ack;
        tx_timeout_i = tmo; cfg_clr_i = clr;
        #1;
        if (we || wl) check("wr_ready", wr_ready_o, m_cnt[wep] < 2);
        arm_now = 1'b0;
        if (clr) begin
            model_clear();
        end else begin
            if (req && !m_armed) begin
                if (m_cnt[tep] > 0) begin
                    push(1, m_plen[tep][m_head[tep]], m_tog[tep]);
                    arm_now = 1'b1;
                end else begin
                    push(0, 0, 0);
                end
            end
            if (rd && m_armed && !ack && !tmo && (m_rptr < m_plen[m_ep][m_head[m_ep]])) begin
                push(2, m_pdata[m_ep][m_head[m_ep]][m_rptr], 0);
                m_rptr++;
            end
            if ((we || wl) && (m_cnt[wep] < 2)) begin
                if (we) begin
                    m_fill[wep][m_fill_n[wep]] = wd[7:0];
                    m_fill_n[wep]++;
                end
                if (wl || (m_fill_n[wep] == MAXPKT)) begin
                    s = (m_head[wep] + m_cnt[wep]) % 2;
                    for (int i = 0; i < m_fill_n[wep]; i++) m_pdata[wep][s][i] = m_fill[wep][i];
                    m_plen[wep][s] = m_fill_n[wep];
                    m_cnt[wep]++;
                    m_fill_n[wep] = 0;
                end
            end else if (we) begin
                m_ovf[wep] = 1'b1;
            end
            if (m_armed && ack) begin
                m_head[m_ep] = (m_head[m_ep] + 1) % 2;
                m_cnt[m_ep]--;
                m_tog[m_ep] = ~m_tog[m_ep];
                m_armed     = 1'b0;
            end else if (m_armed && tmo) begin
                m_armed = 1'b0;
                m_rptr  = 0;
            end
            if (arm_now) begin
                m_armed = 1'b1;
                m_ep    = tep;
                m_rptr  = 0;
            end
        end
        @(posedge clk_i);
        #1;
        clear_inputs();
        check("wr_ovf", wr_ovf_o, m_ovf);
    endtask

    task automatic wr(input int ep, input int d, input bit last); cyc(1, ep, d, last, 0, 0, 0, 0, 0, 0); endtask
    task automatic wlast(input int ep); cyc(0, ep, 0, 1, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_req(input int ep); cyc(0, 0, 0, 0, 1, ep, 0, 0, 0, 0); endtask
    task automatic do_rd(input int n); for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0); endtask
    task automatic do_ack(); cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); endtask
    task automatic do_tmo(); cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); endtask
    task automatic do_clr(); cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); endtask
    task automatic idle(input int n); for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

    task automatic mon_expect(input int kind, input logic [31:0] v, input logic [31:0] a);
        exp_t it;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_event: got kind %0d value 0x%0h, required no event at %0t", kind, v, $time);
        end else begin
            it = exp_q.pop_front();
            check("event_kind", kind, it.kind);
            if (kind == 1) begin
                check("arm_len", v, it.val);
                check("arm_pid", a, it.aux);
            end else if (kind == 2) begin
                check("tx_data", v, it.val);
            end
        end
    endtask

    bit rd_seen    = 1'b0;
    bit prev_valid = 1'b0;

    // A pop accepted at this edge returns its byte after the edge.
    always @(posedge clk_i) begin
        rd_seen = rst_ni && tx_rd_i && tx_valid_o;
    end

    // Monitor: compare each presented response against the head of the expectation queue.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (tx_nak_o) mon_expect(0, 32'd0, 32'd0);
            if (tx_valid_o && !prev_valid) mon_expect(1, tx_len_o, tx_data1_o);
            if (rd_seen) mon_expect(2, tx_data_o, 32'd0);
        end
        prev_valid = tx_valid_o;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0;
        clear_inputs();
        model_clear();
        #3;
        check("rst_tx_valid", tx_valid_o, 1'b0);
        check("rst_tx_nak", tx_nak_o, 1'b0);
        check("rst_tx_len", tx_len_o, 0);
        check("rst_tx_data1", tx_data1_o, 1'b0);
        check("rst_tx_data", tx_data_o, 8'h00);
        check("rst_wr_ovf", wr_ovf_o, 0);
        check("rst_wr_ready", wr_ready_o, 1'b1);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Full packet auto-commit, read-out, ack and toggle flip.
        for (int i = 1; i <= 8; i++) wr(1, i, 1'b0);
        do_req(1);
        check("t1_len", tx_len_o, 8);
        check("t1_pid", tx_data1_o, 1'b0);
        do_rd(8);
        do_ack();
        check("t1_valid_off", tx_valid_o, 1'b0);
        wr(1, 8'h55, 1'b1);
        do_req(1);
        check("t1_pid_next", tx_data1_o, 1'b1);
        do_rd(1);
        do_ack();

        // NAK on empty endpoint, then a zero-length packet.
        do_req(0);
        check("t2_nak", tx_nak_o, 1'b1);
        check("t2_valid", tx_valid_o, 1'b0);
        wlast(0);
        do_req(0);
        check("t2_zlp_valid", tx_valid_o, 1'b1);
        check("t2_zlp_len", tx_len_o, 0);
        do_ack();

        // Both banks full, overflow, then free one bank by serving it.
        wr(1, 8'hA1, 1'b0); wr(1, 8'hA2, 1'b0); wr(1, 8'hA3, 1'b1);
        wr(1, 8'hB1, 1'b0); wr(1, 8'hB2, 1'b0); wr(1, 8'hB3, 1'b1);
        wr_ep_i = 1'b1;
        #1;
        check("t3_ready_full", wr_ready_o, 1'b0);
        wr(1, 8'hCC, 1'b0);
        check("t3_ovf", wr_ovf_o[1], 1'b1);
        do_req(1);
        do_rd(3);
        do_ack();
        wr_ep_i = 1'b1;
        #1;
        check("t3_ready_free", wr_ready_o, 1'b1);
        do_req(1);

        // Timeout mid-read, then a retry resends from offset 0 with the same PID.
        do_rd(2);
        do_tmo();
        check("t4_valid_off", tx_valid_o, 1'b0);
        do_req(1);
        check("t4_pid_kept", tx_data1_o, 1'b1);
        do_rd(3);
        do_ack();

        // Flush during ARMED clears overflow and toggles and drops the armed packet.
        wr(1, 8'h61, 1'b0); wr(1, 8'h62, 1'b1);
        do_req(1);
        do_rd(1);
        do_clr();
        check("t5_valid_off", tx_valid_o, 1'b0);
        check("t5_ovf_clr", wr_ovf_o, 0);
        do_req(1);
        check("t5_nak", tx_nak_o, 1'b1);
        wr(0, 8'h71, 1'b1);
        do_req(0);
        check("t5_pid_clr", tx_data1_o, 1'b0);
        do_ack();

        // Randomised traffic on both endpoints, including same-cycle write/ack collisions.
        for (int it = 0; it < 3000; it++) begin
            int r, wep, tep;
            bit b_we, b_wl, b_req, b_rd, b_ack, b_tmo, b_clr;
            r     = $urandom_range(0, 199);
            b_clr = (r == 0);
            b_we  = !b_clr && ($urandom_range(0, 1) == 1);
            b_wl  = !b_clr && ($urandom_range(0, 9) == 0);
            wep   = $urandom_range(0, NUM_EP - 1);
            tep   = $urandom_range(0, NUM_EP - 1);
            b_req = 1'b0; b_rd = 1'b0; b_ack = 1'b0; b_tmo = 1'b0;
            if (!b_clr) begin
                r = $urandom_range(0, 9);
                if (!m_armed) b_req = (r < 4);
                else if (r < 5) b_rd = (m_rptr < m_plen[m_ep][m_head[m_ep]]);
                else if (r == 5) b_ack = 1'b1;
                else if (r == 6) b_tmo = 1'b1;
                else if (r == 7) b_req = 1'b1;
                else if (r == 8) begin b_ack = 1'b1; b_tmo = 1'b1; end
            end
            cyc(b_we, wep, $urandom_range(0, 255), b_wl, b_req, tep, b_rd, b_ack, b_tmo, b_clr);
        end
        do_clr();
        idle(2);

        // Asynchronous reset while a packet is being read.
        wr(0, 8'h11, 1'b0); wr(0, 8'h22, 1'b1);
        do_req(0);
        do_rd(2);
        idle(2);
        check("q_empty_pre_reset", exp_q.size(), 0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_tx_valid", tx_valid_o, 1'b0);
        check("arst_tx_len", tx_len_o, 0);
        check("arst_tx_data", tx_data_o, 8'h00);
        check("arst_tx_data1", tx_data1_o, 1'b0);
        check("arst_wr_ovf", wr_ovf_o, 0);
        model_clear();
        exp_q.delete();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        do_req(0);
        check("arst_nak", tx_nak_o, 1'b1);
        idle(3);
        check("q_empty_end", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
